// File: rtl/tensor_reader.sv
// Read-only traversal of a ROWS x COLS tensor, streaming one element per
// two cycles in row- or column-major order over a valid/ready output.
module tensor_reader #(
  parameter int ROWS     = 2,
  parameter int COLS     = 4,
  parameter int ROW_BITS = 2,
  parameter int COL_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                col_major,
  input  logic                abort,
  output logic [ROW_BITS-1:0] sel_r,
  output logic [COL_BITS-1:0] sel_c,
  input  logic [15:0]         param_in,
  output logic [15:0]         out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_eol,
  output logic                out_last,
  output logic                busy,
  output logic                done,
  output logic [1:0]          dbg_state
);

  // Handshake: an element transfers on a rising edge where out_valid and
  // out_ready are both high and abort is low; out_data/out_eol/out_last are
  // held stable while out_valid=1 and out_ready=0.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [ROW_BITS-1:0] ROW_MAX = ROW_BITS'(ROWS - 1);
  localparam logic [COL_BITS-1:0] COL_MAX = COL_BITS'(COLS - 1);

  state_t                r_state;
  state_t                w_next;
  logic [ROW_BITS-1:0]   r_row;
  logic [COL_BITS-1:0]   r_col;
  logic                  r_order;
  logic [15:0]           r_data;
  logic                  r_valid;
  logic                  r_eol;
  logic                  r_last;
  logic                  r_done;
  logic                  w_row_end;
  logic                  w_col_end;
  logic                  w_accept;

  assign w_row_end = (r_row == ROW_MAX);
  assign w_col_end = (r_col == COL_MAX);
  assign w_accept  = (r_state == S_SEND) && out_ready;

  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (start) w_next = S_LOAD;
        S_LOAD: w_next = S_SEND;
        S_SEND: if (out_ready) w_next = r_last ? S_DONE : S_LOAD;
        S_DONE: w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_order <= 1'b0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_eol   <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      if (abort) begin
        r_valid <= 1'b0;
        r_row   <= '0;
        r_col   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_row   <= '0;
              r_col   <= '0;
              r_order <= col_major;
            end
          end
          S_LOAD: begin
            r_data  <= param_in;
            r_valid <= 1'b1;
            r_eol   <= r_order ? w_row_end : w_col_end;
            r_last  <= w_row_end && w_col_end;
          end
          S_SEND: begin
            if (w_accept) begin
              r_valid <= 1'b0;
              if (r_last) begin
                r_done <= 1'b1;
              end else if (r_order) begin
                // Column-major: walk down the column, then step right.
                if (w_row_end) begin
                  r_row <= '0;
                  r_col <= r_col + 1'b1;
                end else begin
                  r_row <= r_row + 1'b1;
                end
              end else begin
                if (w_col_end) begin
                  r_col <= '0;
                  r_row <= r_row + 1'b1;
                end else begin
                  r_col <= r_col + 1'b1;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sel_r     = r_row;
  assign sel_c     = r_col;
  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign out_eol   = r_eol;
  assign out_last  = r_last;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_tensor_reader.sv
// Directed bench for tensor_reader (2x3 tensor, storage [r][c] = 16'h0010*r + c)
// with an expected-element queue drained by an independent monitor.
module tb_tensor_reader;

  localparam int ROWS = 2;
  localparam int COLS = 3;
  localparam int RB   = 2;
  localparam int CB   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          col_major = 1'b0;
  logic          abort = 1'b0;
  logic [RB-1:0] sel_r;
  logic [CB-1:0] sel_c;
  logic [15:0]   param_in;
  logic [15:0]   out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_eol;
  logic          out_last;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  int errors = 0;
  int checks = 0;
  logic [17:0] exp_q[$];
  logic        pend_done = 1'b0;
  int          done_cnt = 0;
  int          cyc = 0;
  int          prev_hs = 0;
  logic        has_prev = 1'b0;
  logic        chk_rate = 1'b0;

  tensor_reader #(.ROWS(ROWS), .COLS(COLS), .ROW_BITS(RB), .COL_BITS(CB)) dut (
    .clk(clk), .rst(rst), .start(start), .col_major(col_major), .abort(abort),
    .sel_r(sel_r), .sel_c(sel_c), .param_in(param_in), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_eol(out_eol),
    .out_last(out_last), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // Storage model
  assign param_in = 16'(sel_r) * 16'h0010 + 16'(sel_c);

  // Clock/reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      cyc++;
      if (pend_done) begin
        chk("done_pulse", 32'(done), 32'd1);
        pend_done = 1'b0;
      end else if (done) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got 1 expected 0");
      end
      if (done) done_cnt++;
      if (out_valid && out_ready && !abort) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_elem: got %0h expected none", out_data);
        end else begin
          logic [17:0] e;
          e = exp_q.pop_front();
          chk("elem", {14'd0, out_data, out_eol, out_last}, {14'd0, e});
          if (e[0]) pend_done = 1'b1;
        end
        if (chk_rate && has_prev) chk("rate", 32'(cyc - prev_hs), 32'd2);
        prev_hs  = cyc;
        has_prev = 1'b1;
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d, input logic eol, input logic last);
    exp_q.push_back({d, eol, last});
  endtask

  task automatic push_seq(input logic cm);
    for (int i = 0; i < ROWS * COLS; i++) begin
      int r, c;
      r = cm ? (i % ROWS) : (i / COLS);
      c = cm ? (i / ROWS) : (i % COLS);
      push(16'(r * 16 + c), cm ? (r == ROWS - 1) : (c == COLS - 1),
           (r == ROWS - 1) && (c == COLS - 1));
    end
  endtask

  task automatic pulse_start(input logic cm);
    start = 1'b1;
    col_major = cm;
    tick();
    start = 1'b0;
    col_major = 1'b0;
  endtask

  task automatic wait_elem(input logic [15:0] d);
    int n;
    n = 0;
    while (!(out_valid && out_data == d) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL wait_elem: got timeout expected element %0h", d);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    tick();
    tick();
    chk({name, "_idle"}, 32'(busy), 32'd0);
    chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic begin_test(input logic rate);
    has_prev = 1'b0;
    chk_rate = rate;
    done_cnt = 0;
  endtask

  initial begin
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sel", {28'd0, sel_r, sel_c}, 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    rst = 1'b0;
    tick();

    // Row-major, ready held high
    begin_test(1'b1);
    push_seq(1'b0);
    pulse_start(1'b0);
    wait_idle("row");
    chk("row_done_cnt", 32'(done_cnt), 32'd1);
    chk("row_final_sel", {28'd0, sel_r, sel_c}, {28'd0, 2'd1, 4'd2});

    // Column-major
    begin_test(1'b1);
    push_seq(1'b1);
    pulse_start(1'b1);
    wait_idle("col");
    chk("col_done_cnt", 32'(done_cnt), 32'd1);

    // Backpressure on element 0001
    begin_test(1'b0);
    push_seq(1'b0);
    pulse_start(1'b0);
    wait_elem(16'h0001);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(out_data), 32'h0001);
    end
    out_ready = 1'b1;
    wait_idle("bp");
    chk("bp_done_cnt", 32'(done_cnt), 32'd1);

    // Abort in SEND of 0010; the concurrent handshake is discarded
    begin_test(1'b0);
    push(16'h0000, 1'b0, 1'b0);
    push(16'h0001, 1'b0, 1'b0);
    push(16'h0002, 1'b1, 1'b0);
    pulse_start(1'b0);
    wait_elem(16'h0010);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sel", {28'd0, sel_r, sel_c}, 32'd0);
    wait_idle("abort");
    chk("abort_done_cnt", 32'(done_cnt), 32'd0);
    begin_test(1'b1);
    push_seq(1'b0);
    pulse_start(1'b0);
    wait_idle("restart");
    chk("restart_done_cnt", 32'(done_cnt), 32'd1);

    // Starts while busy and in DONE are ignored
    begin_test(1'b1);
    push_seq(1'b0);
    pulse_start(1'b0);
    tick();
    tick();
    pulse_start(1'b0);
    for (int n = 0; n < 100 && !done; n++) tick();
    chk("ign_done_seen", 32'(done), 32'd1);
    pulse_start(1'b1);
    for (int i = 0; i < 10; i++) tick();
    wait_idle("ignore");
    chk("ign_done_cnt", 32'(done_cnt), 32'd1);

    // Asynchronous reset in SEND of 0011
    begin_test(1'b0);
    push(16'h0000, 1'b0, 1'b0);
    push(16'h0001, 1'b0, 1'b0);
    push(16'h0002, 1'b1, 1'b0);
    push(16'h0010, 1'b0, 1'b0);
    out_ready = 1'b0;
    pulse_start(1'b0);
    out_ready = 1'b1;
    wait_elem(16'h0011);
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_flags", {29'd0, out_eol, out_last, done}, 32'd0);
    chk("arst_data", 32'(out_data), 32'd0);
    chk("arst_sel", {28'd0, sel_r, sel_c}, 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("arst_quiet", 32'(out_valid), 32'd0);
    wait_idle("arst");
    chk("arst_done_cnt", 32'(done_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
